// File: rtl/fixedpoint_pkg.sv
// Fixed-point datapath defaults shared by the divider and multiplier, plus the
// common three-state FSM encoding used by both iterative units.
package fixedpoint_pkg;
  localparam int FRAC_W_DEF = 8;
  localparam int INT_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;
endpackage

// File: rtl/sns_multiplier_if.sv
// Request/result bundle for the shift-and-add multiplier.
interface sns_multiplier_if #(
  parameter int FRAC_W = fixedpoint_pkg::FRAC_W_DEF,
  parameter int INT_W  = fixedpoint_pkg::INT_W_DEF
);
  logic                    start;
  logic [FRAC_W-1:0]       frac;
  logic [INT_W-1:0]        mcand;
  logic                    busy;
  logic                    done;
  logic [INT_W+FRAC_W-1:0] product;
  logic [INT_W-1:0]        product_int;

  modport master (output start, frac, mcand, input busy, done, product, product_int);
  modport slave  (input start, frac, mcand, output busy, done, product, product_int);
endinterface

// File: rtl/sns_mul_step.sv
// One shift-add iteration: doubles the running sum and adds the multiplicand
// when the current fraction bit (MSB first) is set.
module sns_mul_step #(
  parameter int FRAC_W = 8,
  parameter int INT_W  = 7
) (
  input  logic [INT_W+FRAC_W-1:0] acc_i,
  input  logic                    bit_i,
  input  logic [INT_W-1:0]        mcand_i,
  output logic [INT_W+FRAC_W-1:0] acc_o
);
  localparam int ACC_W = INT_W + FRAC_W;

  // The dropped MSB is always zero: the final sum is bounded by ACC_W bits.
  assign acc_o = {acc_i[ACC_W-2:0], 1'b0} + (bit_i ? ACC_W'(mcand_i) : '0);
endmodule

// File: rtl/sns_multiplier.sv
// Iterative unsigned integer x Q0.FRAC_W multiplier, one fraction bit per
// cycle; result holds on the outputs until the next accepted start.
module sns_multiplier
  import fixedpoint_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int INT_W  = INT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  sns_multiplier_if.slave  bus
);
  localparam int ACC_W = INT_W + FRAC_W;
  localparam int CNT_W = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_W - 1);

  fsm_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [INT_W-1:0]  mcand_q, mcand_d;
  logic [ACC_W-1:0]  step_acc;
  logic              accept;

  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  sns_mul_step #(.FRAC_W(FRAC_W), .INT_W(INT_W)) u_step (
    .acc_i   (acc_q),
    .bit_i   (frac_q[cnt_q]),
    .mcand_i (mcand_q),
    .acc_o   (step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      frac_q  <= '0;
      mcand_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      frac_q  <= frac_d;
      mcand_q <= mcand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operands latch only on accept, so input churn during BUSY is inert.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    frac_d  = frac_q;
    mcand_d = mcand_q;
    if (accept) begin
      cnt_d   = CNT_LAST;
      acc_d   = '0;
      frac_d  = bus.frac;
      mcand_d = bus.mcand;
    end else if (state_q == ST_BUSY) begin
      acc_d = step_acc;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    bus.busy        = (state_q == ST_BUSY);
    bus.done        = (state_q == ST_DONE);
    bus.product     = acc_q;
    bus.product_int = acc_q[ACC_W-1:FRAC_W];
  end
endmodule

// File: tb/tb_sns_multiplier.sv
// Directed bench for sns_multiplier: an arithmetic reference model checked
// every cycle, plus hand-computed literal results and latencies.
module tb_sns_multiplier;
  localparam int FRAC_W = 8;
  localparam int INT_W  = 7;
  localparam int ACC_W  = FRAC_W + INT_W;
  localparam int LAT    = FRAC_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  sns_multiplier_if #(.FRAC_W(FRAC_W), .INT_W(INT_W)) bus ();

  sns_multiplier #(.FRAC_W(FRAC_W), .INT_W(INT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: age counts cycles since an accepted request (0 = none in flight).
  int               age;
  logic [ACC_W-1:0] exp_prod;
  bit               prod_valid;

  always @(posedge clk) begin
    if (rst) begin
      age        <= 0;
      exp_prod   <= '0;
      prod_valid <= 1'b1;
    end else if ((age == 0 || age == LAT) && bus.start) begin
      age        <= 1;
      exp_prod   <= ACC_W'(int'(bus.frac) * int'(bus.mcand));
      prod_valid <= 1'b0;
    end else if (age == LAT) begin
      age <= 0;
    end else if (age > 0) begin
      age <= age + 1;
      if (age == FRAC_W) prod_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(age >= 1 && age <= FRAC_W));
      chk("done", 32'(bus.done), 32'(age == LAT));
      if (prod_valid) begin
        chk("product", 32'(bus.product), 32'(exp_prod));
        chk("product_int", 32'(bus.product_int), 32'(exp_prod >> FRAC_W));
      end
      if (bus.done) n_done++;
    end
  end

  // Counts negedges until done is seen; an expired bound is a miscompare.
  task automatic wait_done(input bit toggle, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (toggle) bus.start = bus.done ? 1'b0 : 1'($urandom);
      if (toggle) bus.frac  = 8'($urandom);
      if (toggle) bus.mcand = 7'($urandom);
    end while (!bus.done && n < 40);
    if (!bus.done) chk("done_timeout", 32'(n), 32'(LAT));
  endtask

  task automatic do_op(input string nm, input logic [7:0] f, input logic [6:0] m,
                       input int exp_p, input int exp_i);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.frac  = f;
    bus.mcand = m;
    wait_done(1'b1, n);
    bus.start = 1'b0;
    chk({nm, "_latency"}, 32'(n), 32'(LAT));
    chk({nm, "_product"}, 32'(bus.product), 32'(exp_p));
    chk({nm, "_int"}, 32'(bus.product_int), 32'(exp_i));
  endtask

  initial begin
    int n, d0;
    bus.start = 1'b0;
    bus.frac  = '0;
    bus.mcand = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);

    do_op("half",    8'h80, 7'd100, 12800, 50);
    do_op("max",     8'hFF, 7'd127, 32385, 126);
    do_op("third3",  8'h55, 7'd3,   255,   0);
    do_op("third6",  8'h55, 7'd6,   510,   1);
    do_op("zero_f",  8'h00, 7'd127, 0,     0);
    do_op("zero_m",  8'hFF, 7'd0,   0,     0);

    // Back-to-back with start held high throughout.
    @(negedge clk);
    bus.start = 1'b1;
    bus.frac  = 8'h40;
    bus.mcand = 7'd8;
    wait_done(1'b0, n);
    chk("b2b1_latency", 32'(n), 32'(LAT));
    chk("b2b1_product", 32'(bus.product), 32'd512);
    chk("b2b1_int", 32'(bus.product_int), 32'd2);
    bus.frac  = 8'hC0;
    bus.mcand = 7'd10;
    @(negedge clk);
    bus.frac  = 8'h11;
    bus.mcand = 7'd99;
    n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("b2b2_period", 32'(n), 32'(LAT));
    chk("b2b2_product", 32'(bus.product), 32'd1920);
    chk("b2b2_int", 32'(bus.product_int), 32'd7);
    repeat (2) @(negedge clk);
    chk("b2b_idle_product", 32'(bus.product), 32'd1920);

    // Reset at the fourth compute edge aborts the request silently.
    @(negedge clk);
    bus.start = 1'b1;
    bus.frac  = 8'hFF;
    bus.mcand = 7'd127;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_product", 32'(bus.product), 32'd0);
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'(d0));

    do_op("after_abort", 8'hC0, 7'd10, 1920, 7);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
